pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

- Parametrised hazard, forwarding and halt-drain controller for the in-order RISC-V pipeline.
- Tracks every in-flight destination write from EX through WB and derives:
  - the ID-stage stall,
  - the EX-stage operand forward selects,
  - the WB→ID register bypass,
  - branch-flush bubbles,
  - the drain-then-halt sequence for ecall.
- Generalises the fixed two-source forwarding and single-cycle load-use stall to a configurable pipeline depth and load latency, and adds a memory-wait freeze.

## Interface
Parameters:
- REG_AW, 5, register address width
- DEPTH, 3, tracked positions: 0 = EX … DEPTH-1 = WB; legal range 3..8
- LOAD_LAT, 1, extra cycles before a load result can be forwarded; legal range 1..DEPTH-2
- SEL_W, $clog2(DEPTH), forward-select width (derived)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low; clears all state
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_AW  ID source registers
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  REG_AW  ID destination
- id_reg_write  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- id_halt  in  1  ID instruction is a halting ecall
- ex_flush  in  1  taken branch/jump resolved in EX; discard the ID instruction
- mem_wait  in  1  data memory not ready; freeze the pipeline
- stall  out  1  hold PC and IF/ID; inject a bubble into EX
- fwd_sel_rs1, fwd_sel_rs2  out  SEL_W  EX operand source: 0 = ID/EX operand, k = position-k result
- id_byp_rs1, id_byp_rs2  out  1  ID operand takes the WB write data
- fetch_hold  out  1  stop fetching; a halt is in flight
- is_halted  out  1  halt reached WB; sticky

## Operation
Per-position entry state:
- v, rd, r (ready position: 0 for non-loads, LOAD_LAT for loads), h (halt flag).
- Position 0 additionally stores the rs1/rs2 and used bits of the EX instruction.
- Entries with rd == 0 or reg_write == 0 are stored with v = 0, but h is still carried.

Advance:
- Each edge with mem_wait == 0, entries shift p → p+1. The WB entry retires.
- Position 0 loads the ID instruction when id_valid && !stall && !ex_flush. Otherwise it loads a bubble (all zero).
- mem_wait == 1: all state holds; stall is forced to 1; ex_flush is ignored.

Stall (combinational):
- Applies to each used ID source rs ≠ 0.
- Take the youngest matching valid entry at position p.
- stall = 1 if p < r.
- Only the youngest match is considered; older matches are shadowed.

Forwarding (combinational):
- For each used EX source, fwd_sel is the smallest q in 1..DEPTH-1 whose entry is valid and rd matches; otherwise fwd_sel = 0.
- q > r is guaranteed by the stall logic, so forwarded data is always ready.

ID bypass:
- id_byp_rsX = 1 when the WB entry is valid and its rd equals the ID rsX (rsX ≠ 0).

Precedence:
- ex_flush with stall: flush wins. stall = 0, and a bubble enters position 0.

Halt:
- fetch_hold = 1 from the edge that enqueues an h entry until reset.
- When the h entry occupies position DEPTH-1, is_halted goes to 1 on the next edge and stays set.
- If the h instruction is flushed before enqueue, nothing happens.

## Timing
- Reset: all entries invalid; stall, fwd_sel*, id_byp*, fetch_hold, is_halted = 0.
- stall, fwd_sel and id_byp: combinational from state and ID inputs; no added latency.
- Load-use with LOAD_LAT = L: exactly L bubble cycles (0 for ALU producers).
- is_halted: asserts DEPTH+1 edges after the halt instruction leaves ID, plus any mem_wait cycles.
- Reset asserted mid-operation clears everything immediately, including sticky is_halted.

## Configuration
HAZARD_ID_BYPASS_EN
- Defined: WB→ID bypass as above.
- Undefined:
  - id_byp_* tie to 0.
  - A WB-position match counts as a hazard, so stall = 1 for one cycle and the instruction re-reads after the register-file write.

## Structure
- Shared package pipe_pkg:
  - DEPTH/LOAD_LAT defaults,
  - the entry struct {v, rd, r, h},
  - the SEL_W function,
  - the x0 constant.
- One sub-module, hazard_match: parametrised youngest-match priority search over the entries, returning hit and position. Instantiated once per source per stage.

## Test plan
- ALU chain: add x5 then sub x6,x5,x1 (DEPTH=3) → stall = 0; EX fwd_sel_rs1 = 1.
- Load-use: lw x7 then add x8,x7,x0 with LOAD_LAT=1 → 1 stall cycle, then fwd_sel_rs1 = 2; with LOAD_LAT=2, DEPTH=5 → 2 stalls.
- Shadowing: addi x9 twice back-to-back, then a consumer of x9 → fwd_sel = 1 (youngest), never 2.
- Flush during load-use stall → stall drops the same cycle; bubble enters EX; x0 is never forwarded.
- mem_wait held 3 cycles with a load in position 1 → entries frozen, stall = 1 throughout, fwd_sel is unchanged on release.
- Halt: ecall enqueued → fetch_hold = 1 next cycle; is_halted = 1 after DEPTH+1 edges; reset low mid-drain clears both.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Entry layout, size defaults and the forward-select width helper.
package pipe_pkg;

    localparam int DEPTH_DEF = 3;
    localparam int LOAD_LAT_DEF = 1;
    localparam int MAX_AW = 8;
    localparam int R_W = 4;

    localparam logic [MAX_AW-1:0] X0 = '0;

    typedef struct packed {
        logic              v;
        logic [MAX_AW-1:0] rd;
        logic [R_W-1:0]    r;
        logic              h;
    } entry_t;

    function automatic int sel_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-match priority search over tracked destination entries.
// Returns the lowest matching index offset by BASE.
module hazard_match
    import pipe_pkg::*;
#(
    parameter int N = 3,
    parameter int BASE = 0,
    parameter int SEL_W = 2
) (
    input  logic                       en,
    input  logic [MAX_AW-1:0]          key,
    input  logic [N-1:0]               v,
    input  logic [N-1:0][MAX_AW-1:0]   rd,
    output logic                       hit,
    output logic [SEL_W-1:0]           pos
);

    // scan oldest to youngest so the youngest match wins
    always_comb begin
        hit = 1'b0;
        pos = '0;
        if (en && key != X0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (v[i] && rd[i] == key) begin
                    hit = 1'b1;
                    pos = SEL_W'(i + BASE);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and halt-drain controller for the in-order pipe.
// Optional WB-to-ID bypass: define HAZARD_ID_BYPASS_EN.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH = DEPTH_DEF,
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    parameter int SEL_W = sel_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              id_halt,
    input  logic              ex_flush,
    input  logic              mem_wait,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_sel_rs1,
    output logic [SEL_W-1:0]  fwd_sel_rs2,
    output logic              id_byp_rs1,
    output logic              id_byp_rs2,
    output logic              fetch_hold,
    output logic              is_halted
);

`ifdef HAZARD_ID_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [SEL_W-1:0] WB_POS = SEL_W'(DEPTH - 1);

    entry_t            ent [DEPTH];
    logic [MAX_AW-1:0] ex_rs1, ex_rs2;
    logic              ex_u1, ex_u2;
    logic              hold_q, halted_q;

    logic [MAX_AW-1:0] rs1_x, rs2_x, rd_x;
    logic [DEPTH-1:0]  vv;
    logic [DEPTH-1:0][MAX_AW-1:0] rdv;

    logic              id_hit1, id_hit2, ex_hit1, ex_hit2;
    logic [SEL_W-1:0]  id_pos1, id_pos2, ex_pos1, ex_pos2;
    logic [R_W-1:0]    r1, r2;
    logic              haz1, haz2, haz, enq;
    entry_t            new_ent;

    // widen register ids and flatten entry fields for the searches
    always_comb begin
        rs1_x = '0;
        rs2_x = '0;
        rd_x = '0;
        rs1_x[REG_AW-1:0] = id_rs1;
        rs2_x[REG_AW-1:0] = id_rs2;
        rd_x[REG_AW-1:0] = id_rd;
        for (int p = 0; p < DEPTH; p++) begin
            vv[p] = ent[p].v;
            rdv[p] = ent[p].rd;
        end
    end

    hazard_match #(.N(DEPTH), .BASE(0), .SEL_W(SEL_W)) u_id1 (
        .en(id_rs1_used), .key(rs1_x), .v(vv), .rd(rdv),
        .hit(id_hit1), .pos(id_pos1)
    );

    hazard_match #(.N(DEPTH), .BASE(0), .SEL_W(SEL_W)) u_id2 (
        .en(id_rs2_used), .key(rs2_x), .v(vv), .rd(rdv),
        .hit(id_hit2), .pos(id_pos2)
    );

    hazard_match #(.N(DEPTH-1), .BASE(1), .SEL_W(SEL_W)) u_ex1 (
        .en(ex_u1), .key(ex_rs1),
        .v(vv[DEPTH-1:1]), .rd(rdv[DEPTH-1:1]),
        .hit(ex_hit1), .pos(ex_pos1)
    );

    hazard_match #(.N(DEPTH-1), .BASE(1), .SEL_W(SEL_W)) u_ex2 (
        .en(ex_u2), .key(ex_rs2),
        .v(vv[DEPTH-1:1]), .rd(rdv[DEPTH-1:1]),
        .hit(ex_hit2), .pos(ex_pos2)
    );

    // stall when the youngest producer is not yet at its ready position
    always_comb begin
        r1 = '0;
        r2 = '0;
        for (int p = 0; p < DEPTH; p++) begin
            if (SEL_W'(p) == id_pos1) r1 = ent[p].r;
            if (SEL_W'(p) == id_pos2) r2 = ent[p].r;
        end
        haz1 = id_hit1 && ((R_W'(id_pos1) < r1) ||
               (!BYP && id_pos1 == WB_POS));
        haz2 = id_hit2 && ((R_W'(id_pos2) < r2) ||
               (!BYP && id_pos2 == WB_POS));
        haz = haz1 || haz2;
        enq = id_valid && !haz && !ex_flush;
        stall = mem_wait || (haz && !ex_flush);
    end

    // build the entry entering EX; a bubble is all zero
    always_comb begin
        new_ent = '0;
        if (enq) begin
            new_ent.v = id_reg_write && rd_x != X0;
            new_ent.rd = rd_x;
            new_ent.r = id_is_load ? R_W'(LOAD_LAT) : '0;
            new_ent.h = id_halt;
        end
    end

    // shift entries toward WB unless memory is holding the pipe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < DEPTH; p++) ent[p] <= '0;
            ex_rs1 <= '0;
            ex_rs2 <= '0;
            ex_u1 <= 1'b0;
            ex_u2 <= 1'b0;
            hold_q <= 1'b0;
            halted_q <= 1'b0;
        end else if (!mem_wait) begin
            for (int p = DEPTH - 1; p > 0; p--) ent[p] <= ent[p-1];
            ent[0] <= new_ent;
            ex_rs1 <= enq ? rs1_x : '0;
            ex_rs2 <= enq ? rs2_x : '0;
            ex_u1 <= enq && id_rs1_used;
            ex_u2 <= enq && id_rs2_used;
            if (enq && id_halt) hold_q <= 1'b1;
            if (ent[DEPTH-1].h) halted_q <= 1'b1;
        end
    end

    assign fwd_sel_rs1 = ex_hit1 ? ex_pos1 : '0;
    assign fwd_sel_rs2 = ex_hit2 ? ex_pos2 : '0;
    assign fetch_hold = hold_q;
    assign is_halted = halted_q;

`ifdef HAZARD_ID_BYPASS_EN
    assign id_byp_rs1 = ent[DEPTH-1].v && rs1_x != X0 &&
                        ent[DEPTH-1].rd == rs1_x;
    assign id_byp_rs2 = ent[DEPTH-1].v && rs2_x != X0 &&
                        ent[DEPTH-1].rd == rs2_x;
`else
    assign id_byp_rs1 = 1'b0;
    assign id_byp_rs2 = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed scenarios plus random traffic
// compared against an age-based in-flight instruction model.
module tb_pipe_hazard_unit;

    localparam int D = 3;
    localparam int LAT = 1;
    localparam int SW = 2;
`ifdef HAZARD_ID_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic id_valid, id_rs1_used, id_rs2_used;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic id_reg_write, id_is_load, id_halt;
    logic ex_flush, mem_wait;
    logic stall, id_byp_rs1, id_byp_rs2;
    logic fetch_hold, is_halted;
    logic [SW-1:0] fwd_sel_rs1, fwd_sel_rs2;

    int n_chk = 0;
    int n_fail = 0;

    pipe_hazard_unit #(.REG_AW(5), .DEPTH(D), .LOAD_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .id_halt(id_halt),
        .ex_flush(ex_flush), .mem_wait(mem_wait),
        .stall(stall),
        .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
        .id_byp_rs1(id_byp_rs1), .id_byp_rs2(id_byp_rs2),
        .fetch_hold(fetch_hold), .is_halted(is_halted)
    );

    always #5 clk = ~clk;

    // model: issued instructions with their age in advancing edges
    typedef struct {
        int rd; bit wr; bit ld; bit hl; int age;
    } rec_t;
    rec_t q[$];
    int m_ex1, m_ex2;
    bit m_u1, m_u2, m_hold, m_halt;

    function automatic void m_reset();
        q.delete();
        m_ex1 = 0; m_ex2 = 0; m_u1 = 0; m_u2 = 0;
        m_hold = 0; m_halt = 0;
    endfunction

    function automatic bit m_haz(input int rs, input bit used);
        int best = -1;
        int rdy = 0;
        foreach (q[i])
            if (q[i].wr && q[i].rd != 0 && q[i].rd == rs &&
                (best < 0 || q[i].age < best)) begin
                best = q[i].age;
                rdy = q[i].ld ? LAT : 0;
            end
        if (!used || rs == 0 || best < 0) return 0;
        return (best < rdy) || (!BYP && best == D - 1);
    endfunction

    function automatic bit m_byp(input int rs);
        if (!BYP || rs == 0) return 0;
        foreach (q[i])
            if (q[i].age == D - 1 && q[i].wr && q[i].rd == rs)
                return 1;
        return 0;
    endfunction

    function automatic int m_fwd(input int rs, input bit used);
        int best = 0;
        if (!used) return 0;
        foreach (q[i])
            if (q[i].wr && q[i].rd != 0 && q[i].rd == rs &&
                q[i].age >= 1 && (best == 0 || q[i].age < best))
                best = q[i].age;
        return best;
    endfunction

    function automatic bit m_anyhaz();
        return m_haz(int'(id_rs1), id_rs1_used) ||
               m_haz(int'(id_rs2), id_rs2_used);
    endfunction

    function automatic bit m_stall();
        return mem_wait || (m_anyhaz() && !ex_flush);
    endfunction

    function automatic void m_step();
        bit enq;
        rec_t n;
        if (mem_wait) return;
        enq = id_valid && !m_anyhaz() && !ex_flush;
        foreach (q[i]) if (q[i].age == D - 1 && q[i].hl) m_halt = 1;
        foreach (q[i]) q[i].age++;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].age >= D) q.delete(i);
        m_ex1 = enq ? int'(id_rs1) : 0;
        m_ex2 = enq ? int'(id_rs2) : 0;
        m_u1 = enq && id_rs1_used;
        m_u2 = enq && id_rs2_used;
        if (enq) begin
            n.rd = int'(id_rd); n.wr = id_reg_write;
            n.ld = id_is_load; n.hl = id_halt; n.age = 0;
            q.push_back(n);
            if (id_halt) m_hold = 1;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("stall", 32'(stall), 32'(m_stall()));
        chk("fwd1", 32'(fwd_sel_rs1), 32'(m_fwd(m_ex1, m_u1)));
        chk("fwd2", 32'(fwd_sel_rs2), 32'(m_fwd(m_ex2, m_u2)));
        chk("byp1", 32'(id_byp_rs1), 32'(m_byp(int'(id_rs1))));
        chk("byp2", 32'(id_byp_rs2), 32'(m_byp(int'(id_rs2))));
        chk("hold", 32'(fetch_hold), 32'(m_hold));
        chk("halted", 32'(is_halted), 32'(m_halt));
    endtask

    task automatic drive(input bit v, input int r1, input bit u1,
                         input int r2, input bit u2, input int rd,
                         input bit wr, input bit ld, input bit hl);
        id_valid = v;
        id_rs1 = 5'(r1); id_rs1_used = u1;
        id_rs2 = 5'(r2); id_rs2_used = u2;
        id_rd = 5'(rd); id_reg_write = wr;
        id_is_load = ld; id_halt = hl;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_flush = 0;
        mem_wait = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nop();
        reset = 0;
        #1;
        m_reset();
        chk("rst_stall", 32'(stall), 0);
        chk("rst_fwd1", 32'(fwd_sel_rs1), 0);
        chk("rst_hold", 32'(fetch_hold), 0);
        chk("rst_halted", 32'(is_halted), 0);
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    initial begin
        nop();
        m_reset();
        do_reset();

        // ALU chain: add x5; sub x6,x5,x1
        drive(1, 1, 1, 2, 1, 5, 1, 0, 0);
        tick();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
        #1 chk("alu_stall", 32'(stall), 0);
        tick();
        nop();
        #1 chk("alu_fwd1", 32'(fwd_sel_rs1), 1);
        chk("alu_fwd2", 32'(fwd_sel_rs2), 0);
        tick();

        // load-use: lw x7; add x8,x7,x0
        drive(1, 3, 1, 0, 0, 7, 1, 1, 0);
        tick();
        drive(1, 7, 1, 0, 1, 8, 1, 0, 0);
        #1 chk("lu_stall1", 32'(stall), 1);
        tick();
        #1 chk("lu_stall2", 32'(stall), 0);
        tick();
        nop();
        #1 chk("lu_fwd1", 32'(fwd_sel_rs1), 2);
        chk("lu_fwd_x0", 32'(fwd_sel_rs2), 0);
        tick();

        // shadowing: addi x9 twice, then consumer
        drive(1, 0, 1, 0, 0, 9, 1, 0, 0);
        tick();
        tick();
        drive(1, 9, 1, 0, 0, 10, 1, 0, 0);
        #1 chk("sh_stall", 32'(stall), 0);
        tick();
        nop();
        #1 chk("sh_fwd1", 32'(fwd_sel_rs1), 1);
        tick();
        tick();

        // flush during load-use stall
        drive(1, 1, 1, 0, 0, 10, 1, 1, 0);
        tick();
        drive(1, 10, 1, 0, 0, 11, 1, 0, 0);
        #1 chk("fl_pre", 32'(stall), 1);
        ex_flush = 1;
        #1 chk("fl_stall", 32'(stall), 0);
        tick();
        nop();
        #1 chk("fl_bubble", 32'(fwd_sel_rs1), 0);
        tick();

        // writes to x0 are never forwarded
        drive(1, 1, 1, 0, 0, 0, 1, 0, 0);
        tick();
        drive(1, 0, 1, 0, 1, 3, 1, 0, 0);
        #1 chk("x0_stall", 32'(stall), 0);
        tick();
        nop();
        #1 chk("x0_fwd", 32'(fwd_sel_rs1), 0);
        tick();
        tick();

        // WB-position match: bypass or one-cycle stall
        drive(1, 1, 1, 0, 0, 12, 1, 0, 0);
        tick();
        nop();
        tick();
        tick();
        drive(1, 12, 1, 0, 0, 13, 1, 0, 0);
        #1 chk("wb_stall", 32'(stall), 32'(!BYP));
        chk("wb_byp", 32'(id_byp_rs1), 32'(BYP));
        tick();
        nop();
        tick();
        tick();

        // mem_wait freeze with a load in position 1
        drive(1, 1, 1, 0, 0, 11, 1, 1, 0);
        tick();
        drive(1, 11, 1, 0, 0, 14, 1, 0, 0);
        tick();
        mem_wait = 1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("mw_stall", 32'(stall), 1);
            tick();
        end
        mem_wait = 0;
        #1 chk("mw_rel", 32'(stall), 0);
        tick();
        nop();
        #1 chk("mw_fwd1", 32'(fwd_sel_rs1), 2);
        tick();
        tick();

        // halt drain
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        nop();
        #1 chk("h_hold", 32'(fetch_hold), 1);
        for (int k = 1; k < D; k++) tick();
        chk("h_early", 32'(is_halted), 0);
        tick();
        chk("h_halted", 32'(is_halted), 1);
        tick();
        tick();
        chk("h_sticky", 32'(is_halted), 1);
        do_reset();

        // reset mid-drain
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        nop();
        tick();
        do_reset();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) do_reset();
            drive($urandom_range(3, 0) != 0,
                  int'($urandom_range(7, 0)), 1'($urandom),
                  int'($urandom_range(7, 0)), 1'($urandom),
                  int'($urandom_range(7, 0)), 1'($urandom),
                  $urandom_range(2, 0) == 0,
                  $urandom_range(49, 0) == 0);
            ex_flush = $urandom_range(7, 0) == 0;
            mem_wait = $urandom_range(5, 0) == 0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
